demux8_collector: RTL and testbench
===================================

DEMUX8_COLLECTOR -- requirements
Module: demux8_collector

Interface
REQ-001 Parameters: none; channel count fixed at 8, data width per channel fixed at 1 bit.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 din  input  1  serial data bit to be routed to the selected channel.
REQ-005 din_valid  input  1  din/S qualify; a write occurs only when high in COLLECT.
REQ-006 S  input  3  channel select; index k = S[2] + 2*S[1] + 4*S[0] (S=3'b100 selects channel 1, S=3'b001 selects channel 4).
REQ-007 start  input  1  begin a new frame (clears capture state).
REQ-008 out_ready  input  1  downstream accepts the delivered frame.
REQ-009 out  output  8  delivered frame; out[k] = last bit written to channel k.
REQ-010 out_valid  output  1  out holds an undelivered frame.
REQ-011 busy  output  1  high in COLLECT.
REQ-012 written  output  8  per-channel written flags for the current frame.
REQ-013 err_overrun  output  1  sticky; din_valid seen while in HOLD.

Function
REQ-014 FSM states IDLE, COLLECT, HOLD; one-hot or binary encoding at implementer's choice.
REQ-015 IDLE: start=1 -> written<=0, shadow<=0, err_overrun<=0, next COLLECT; din_valid ignored.
REQ-016 COLLECT: din_valid=1 -> shadow[k]<=din, written[k]<=1 on the same edge.
REQ-017 Rewriting an already-written channel overwrites shadow[k]; no error.
REQ-018 When written|(din_valid<<k) equals 8'hFF at an edge: out<=shadow with this cycle's bit merged, out_valid<=1, next HOLD (latency 1 clock from final write to out_valid).
REQ-019 start=1 in COLLECT restarts: written<=0, shadow<=0, stay COLLECT; a simultaneous din_valid write is discarded.
REQ-020 HOLD: out_valid=1 until out_valid&out_ready at an edge, then out_valid<=0.
REQ-021 HOLD handshake with start=1 same edge -> clear written/shadow/err_overrun, next COLLECT; without start -> next IDLE.
REQ-022 HOLD: start without out_ready ignored; din_valid=1 sets err_overrun and writes nothing.
REQ-023 out retains last delivered frame after handshake until next delivery; written remains 8'hFF in IDLE after a delivered frame.
REQ-024 busy = (state==COLLECT), combinational from state.
REQ-025 Invalid S values impossible (all 8 codes map to a channel); invalid FSM state recovers to IDLE.

Reset
REQ-026 reset=1 asynchronously forces: state IDLE, out=8'h00, out_valid=0, busy=0, written=8'h00, err_overrun=0, shadow=8'h00.
REQ-027 Reset mid-COLLECT or mid-HOLD discards partial/undelivered frame; no out_valid pulse after release.
REQ-028 First edge after reset deassert is a normal functional edge.

Verification
REQ-029 Reset, start, write channels 0..7 in order with din=1,0,1,1,0,0,1,0 (S codes per REQ-006) -> out=8'h4D, out_valid high one clock after 8th write, busy low in HOLD.
REQ-030 start, write ch3=1 twice then ch3=0, then the others with 1 -> out=8'hF7; no error.
REQ-031 Frame complete, hold out_ready=0 for 5 cycles with din_valid=1 -> out stable, out_valid held, err_overrun=1; next start after handshake clears it.
REQ-032 HOLD with out_ready=1 and start=1 same edge -> out_valid=0, busy=1, written=8'h00 next cycle.
REQ-033 Assert reset asynchronously (between edges) after 5 writes -> outputs at reset values immediately; 3 further writes without start produce no frame.
REQ-034 start and din_valid on ch2 same edge in COLLECT -> written=8'h00 afterwards.

Source files
------------

// File: rtl/demux8_collector.sv
// Serial 1-bit demux into an 8-channel frame: bits are routed by S into a shadow
// register, and the frame is delivered on `out` once every channel has been written.
module demux8_collector (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic       din_valid,
    input  logic [2:0] S,
    input  logic       start,
    input  logic       out_ready,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       busy,
    output logic [7:0] written,
    output logic       err_overrun,
    output logic [1:0] dbgState
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } stateT;

    stateT state;
    stateT stateNext;

    logic [7:0] shadow;
    logic [2:0] chanIdx;
    logic [7:0] writeMask;
    logic [7:0] mergedShadow;
    logic       frameDone;
    logic       handshake;

    logic clearFrame;
    logic clearErr;
    logic doWrite;
    logic deliver;
    logic releaseOut;
    logic setErr;

    // S is read with bit 0 as the most significant weight: S=3'b100 is channel 1.
    assign chanIdx      = {S[0], S[1], S[2]};
    assign writeMask    = din_valid ? (8'h01 << chanIdx) : 8'h00;
    assign mergedShadow = (shadow & ~writeMask) | (din ? writeMask : 8'h00);
    assign frameDone    = ((written | writeMask) == 8'hFF);

    // Output handshake: a frame is transferred on a rising edge where out_valid
    // and out_ready are both high; out is held stable while out_valid waits.
    assign handshake = out_valid & out_ready;

    assign busy     = (state == COLLECT);
    assign dbgState = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        clearFrame = 1'b0;
        clearErr   = 1'b0;
        doWrite    = 1'b0;
        deliver    = 1'b0;
        releaseOut = 1'b0;
        setErr     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clearFrame = 1'b1;
                    clearErr   = 1'b1;
                    stateNext  = COLLECT;
                end
            end
            COLLECT: begin
                // A restart discards any write presented on the same edge.
                if (start) begin
                    clearFrame = 1'b1;
                end else if (din_valid) begin
                    doWrite = 1'b1;
                    if (frameDone) begin
                        deliver   = 1'b1;
                        stateNext = HOLD;
                    end
                end
            end
            HOLD: begin
                if (din_valid) begin
                    setErr = 1'b1;
                end
                if (handshake) begin
                    releaseOut = 1'b1;
                    if (start) begin
                        clearFrame = 1'b1;
                        clearErr   = 1'b1;
                        stateNext  = COLLECT;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow      <= 8'h00;
            written     <= 8'h00;
            out         <= 8'h00;
            out_valid   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (clearFrame) begin
                shadow  <= 8'h00;
                written <= 8'h00;
            end else if (doWrite) begin
                shadow  <= mergedShadow;
                written <= written | writeMask;
            end

            // The final write's bit is merged straight into the delivered frame.
            if (deliver) begin
                out       <= mergedShadow;
                out_valid <= 1'b1;
            end else if (releaseOut) begin
                out_valid <= 1'b0;
            end

            // A fresh frame started from HOLD clears the flag even if din_valid is high.
            if (clearErr) begin
                err_overrun <= 1'b0;
            end else if (setErr) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux8_collector.sv
// Randomized + directed bench for demux8_collector with a frame-level reference
// model, an expected-frame queue and a per-cycle output monitor.
module tb_demux8_collector;

  logic       clk;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic [2:0] S;
  logic       start;
  logic       out_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;
  logic [7:0] written;
  logic       err_overrun;
  logic [1:0] dbg_state;

  demux8_collector dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .S          (S),
    .start      (start),
    .out_ready  (out_ready),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .written    (written),
    .err_overrun(err_overrun),
    .dbgState   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int PH_IDLE = 0;
  localparam int PH_COLLECT = 1;
  localparam int PH_HOLD = 2;

  int         m_phase;
  logic [7:0] m_written;
  logic [7:0] m_shadow;
  logic [7:0] m_out;
  logic       m_valid;
  logic       m_err;

  logic [7:0] exp_q[$];

  int n_vec;
  int n_fail;
  bit done;
  bit prev_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] sel_of(input int k);
    logic [2:0] s;
    s[2] = 1'((k % 2) != 0);
    s[1] = 1'(((k / 2) % 2) != 0);
    s[0] = 1'(((k / 4) % 2) != 0);
    return s;
  endfunction

  function automatic int chan_of(input logic [2:0] s);
    return int'(s[2]) + 2 * int'(s[1]) + 4 * int'(s[0]);
  endfunction

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_written = 8'h00;
    m_shadow  = 8'h00;
    m_out     = 8'h00;
    m_valid   = 1'b0;
    m_err     = 1'b0;
  endtask

  // Frame rules applied once per rising edge using the inputs present at the edge.
  task automatic model_edge();
    int k;
    int cnt;
    k = chan_of(S);
    if (m_phase == PH_IDLE) begin
      if (start) begin
        m_written = 8'h00;
        m_shadow  = 8'h00;
        m_err     = 1'b0;
        m_phase   = PH_COLLECT;
      end
    end else if (m_phase == PH_COLLECT) begin
      if (start) begin
        m_written = 8'h00;
        m_shadow  = 8'h00;
      end else if (din_valid) begin
        m_shadow[k]  = din;
        m_written[k] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) cnt += int'(m_written[i]);
        if (cnt == 8) begin
          m_out   = m_shadow;
          m_valid = 1'b1;
          m_phase = PH_HOLD;
          exp_q.push_back(m_shadow);
        end
      end
    end else begin
      if (din_valid) m_err = 1'b1;
      if (out_ready) begin
        m_valid = 1'b0;
        if (start) begin
          m_written = 8'h00;
          m_shadow  = 8'h00;
          m_err     = 1'b0;
          m_phase   = PH_COLLECT;
        end else begin
          m_phase = PH_IDLE;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic d, input logic dv, input int k, input logic st, input logic rdy);
    din       = d;
    din_valid = dv;
    S         = sel_of(k);
    start     = st;
    out_ready = rdy;
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic fill_frame(input logic [7:0] pattern);
    logic [7:0] p;
    p = pattern;
    for (int k = 0; k < 8; k++) cyc(p[k], 1'b1, k, 1'b0, 1'b0);
  endtask

  // Reset is raised between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("arst_out", out, 8'h00);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_written", written, 8'h00);
    check("arst_err", err_overrun, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!done) begin
      check("out_valid", out_valid, m_valid);
      check("busy", busy, 1'(m_phase == PH_COLLECT));
      check("written", written, m_written);
      check("err_overrun", err_overrun, m_err);
      check("out", out, m_out);
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL frame: got unexpected frame %0h expected none at %0t", out, $time);
        end else begin
          check("frame", out, exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pat;
    n_vec      = 0;
    n_fail     = 0;
    done       = 1'b0;
    prev_valid = 1'b0;
    reset      = 1'b1;
    din        = 1'b0;
    din_valid  = 1'b0;
    S          = 3'b000;
    start      = 1'b0;
    out_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_out", out, 8'h00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_written", written, 8'h00);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    idle_cyc();

    // Channels 0..7 in order with 1,0,1,1,0,0,1,0.
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
    fill_frame(8'b0100_1101);
    check("seq_out", out, 8'h4D);
    check("seq_valid", out_valid, 1'b1);
    check("seq_busy_hold", busy, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("seq_retained", out, 8'h4D);
    check("seq_written_idle", written, 8'hFF);

    // Overwrite of channel 3, final value 0.
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 3, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 3, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) if (k != 3) cyc(1'b1, 1'b1, k, 1'b0, 1'b0);
    check("ovw_out", out, 8'hF7);
    check("ovw_err", err_overrun, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Overrun while the frame is held.
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
    fill_frame(8'hFF);
    for (int i = 0; i < 5; i++) cyc(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 7)), 1'b0, 1'b0);
    check("ovr_out", out, 8'hFF);
    check("ovr_valid", out_valid, 1'b1);
    check("ovr_err", err_overrun, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("ovr_err_kept", err_overrun, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
    check("ovr_err_cleared", err_overrun, 1'b0);

    // Handshake and restart on the same edge.
    pat = 8'($urandom_range(0, 255));
    fill_frame(pat);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);
    check("hs_start_valid", out_valid, 1'b0);
    check("hs_start_busy", busy, 1'b1);
    check("hs_start_written", written, 8'h00);

    // Asynchronous reset after five writes, then writes without start.
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, k, 1'b0, 1'b0);
    async_reset();
    for (int k = 5; k < 8; k++) cyc(1'b1, 1'b1, k, 1'b0, 1'b0);
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_written", written, 8'h00);

    // Restart on the same edge as a write to channel 2.
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2, 1'b1, 1'b0);
    check("start_write_written", written, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        cyc(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 7)),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 1)));
      end
    end

    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("queue_empty", exp_q.size(), 0);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
